// File: rtl/labeled_array_reader.sv
// Tagged register array with a valid/ready read port that releases a word only when
// the requester's clearance dominates the entry's tag; refused reads return zero.
module labeled_array_reader #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_tag,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_clr,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              rd_resp_denied,
  output logic [7:0]        denied_count
);

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             clr;
  } req_t;

  state_e                       state_q, state_d;
  req_t                         req_q, req_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             tag_q, tag_d;
  logic [DATA_W-1:0]            data_q, data_d;
  logic                         denied_q, denied_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic [DATA_W-1:0]            rd_word;
  logic                         rd_tag;
  logic                         in_range;
  logic                         grant;

  // Indices past DEPTH match no entry, so such writes fall away.
  always_comb begin
    mem_d = mem_q;
    tag_d = tag_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en && wr_idx == IDX_W'(i)) begin
        mem_d[i] = wr_data;
        tag_d[i] = wr_tag;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    rd_tag  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_q.idx == IDX_W'(i)) begin
        rd_word = mem_q[i];
        rd_tag  = tag_q[i];
      end
    end
  end

  assign in_range = {1'b0, req_q.idx} < DEPTH_L;
  assign grant    = in_range && (req_q.clr || !rd_tag);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    denied_d = denied_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (rd_req_valid) begin
          req_d.idx = rd_idx;
          req_d.clr = rd_clr;
          state_d   = LOOKUP;
        end
      end
      LOOKUP: begin
        // Denied path selects a constant, so H data never reaches the output flops.
        data_d   = grant ? rd_word : '0;
        denied_d = !grant;
        if (!grant && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        state_d  = RESP;
      end
      RESP: begin
        if (rd_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      mem_q    <= '0;
      tag_q    <= '0;
      data_q   <= '0;
      denied_q <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      mem_q    <= mem_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
      denied_q <= denied_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rd_req_ready   = (state_q == IDLE);
  assign rd_resp_valid  = (state_q == RESP);
  assign rd_resp_data   = data_q;
  assign rd_resp_denied = denied_q;
  assign denied_count   = cnt_q;

endmodule

// File: tb/tb_labeled_array_reader.sv
// Drives a DEPTH=4 and a DEPTH=3 instance in lockstep and compares both
// against a plain array model of the tagged store and the denial counter.
module tb_labeled_array_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [15:0] wr_data;
  logic        wr_tag;
  logic        rd_req_valid;
  logic [1:0]  rd_idx;
  logic        rd_clr;
  logic        rd_resp_ready;

  logic        rdy4, vld4, den4, rdy3, vld3, den3;
  logic [15:0] data4, data3;
  logic [7:0]  cnt4, cnt3;

  int total = 0;
  int bad   = 0;

  // model: index 0 mirrors the DEPTH=4 build, index 1 the DEPTH=3 build
  int          dep [2] = '{4, 3};
  logic [15:0] mem_m [2][4];
  bit          tag_m [2][4];
  int          cnt_m [2];

  always #5 clk = ~clk;

  labeled_array_reader #(.DATA_W(16), .DEPTH(4), .IDX_W(2)) u4 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_tag(wr_tag), .rd_req_valid(rd_req_valid), .rd_req_ready(rdy4),
    .rd_idx(rd_idx), .rd_clr(rd_clr), .rd_resp_valid(vld4),
    .rd_resp_ready(rd_resp_ready), .rd_resp_data(data4),
    .rd_resp_denied(den4), .denied_count(cnt4));

  labeled_array_reader #(.DATA_W(16), .DEPTH(3), .IDX_W(2)) u3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_tag(wr_tag), .rd_req_valid(rd_req_valid), .rd_req_ready(rdy3),
    .rd_idx(rd_idx), .rd_clr(rd_clr), .rd_resp_valid(vld3),
    .rd_resp_ready(rd_resp_ready), .rd_resp_data(data3),
    .rd_resp_denied(den3), .denied_count(cnt3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      cnt_m[m] = 0;
      for (int i = 0; i < 4; i++) begin
        mem_m[m][i] = '0;
        tag_m[m][i] = 1'b0;
      end
    end
  endtask

  task automatic model_write(input int idx, input logic [15:0] d, input bit t);
    for (int m = 0; m < 2; m++)
      if (idx < dep[m]) begin
        mem_m[m][idx] = d;
        tag_m[m][idx] = t;
      end
  endtask

  function automatic bit allowed(input int m, input int idx, input bit clr);
    return (idx < dep[m]) && (clr || !tag_m[m][idx]);
  endfunction

  // Computes expected response for both builds and bumps the model counters.
  task automatic predict(input int idx, input bit clr,
                         output logic [15:0] ed [2], output bit eden [2]);
    for (int m = 0; m < 2; m++) begin
      eden[m] = !allowed(m, idx, clr);
      ed[m]   = eden[m] ? 16'h0000 : mem_m[m][idx];
      if (eden[m] && cnt_m[m] < 255) cnt_m[m]++;
    end
  endtask

  task automatic chk_resp(input logic [15:0] ed [2], input bit eden [2]);
    chk("resp_valid4", vld4, 1);
    chk("resp_data4", data4, ed[0]);
    chk("resp_denied4", den4, eden[0]);
    chk("resp_req_ready4", rdy4, 0);
    chk("resp_count4", cnt4, cnt_m[0]);
    chk("resp_valid3", vld3, 1);
    chk("resp_data3", data3, ed[1]);
    chk("resp_denied3", den3, eden[1]);
    chk("resp_count3", cnt3, cnt_m[1]);
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [15:0] d, input bit t);
    wr_en = 1'b1; wr_idx = idx; wr_data = d; wr_tag = t;
    tick();
    wr_en = 1'b0;
    model_write(idx, d, t);
  endtask

  task automatic do_read(input logic [1:0] idx, input bit clr, input int hold, input bit wr_in_resp);
    logic [15:0] ed [2];
    bit          eden [2];
    predict(idx, clr, ed, eden);
    chk("idle_req_ready4", rdy4, 1);
    chk("idle_req_ready3", rdy3, 1);
    rd_req_valid = 1'b1; rd_idx = idx; rd_clr = clr; rd_resp_ready = (hold == 0);
    tick();
    rd_req_valid = 1'b0; rd_idx = 2'($urandom); rd_clr = 1'($urandom);
    chk("lookup_req_ready", rdy4, 0);
    chk("lookup_resp_valid", vld4, 0);
    tick();
    for (int h = 0; h <= hold; h++) begin
      wr_en = 1'b0;
      chk_resp(ed, eden);
      if (wr_in_resp && h == 0) begin
        wr_en = 1'b1; wr_idx = idx; wr_data = 16'hA5A5; wr_tag = 1'b0;
      end
      if (h < hold) tick();
    end
    rd_resp_ready = 1'b1;
    tick();
    wr_en = 1'b0;
    if (wr_in_resp) model_write(idx, 16'hA5A5, 1'b0);
    chk("done_req_ready4", rdy4, 1);
    chk("done_resp_valid4", vld4, 0);
    chk("done_count4", cnt4, cnt_m[0]);
    chk("done_req_ready3", rdy3, 1);
  endtask

  initial begin
    logic [15:0] ed [2];
    bit          eden [2];

    reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_tag = 1'b0;
    rd_req_valid = 1'b0; rd_idx = '0; rd_clr = 1'b0; rd_resp_ready = 1'b1;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    chk("rst_req_ready", rdy4, 1);
    chk("rst_resp_valid", vld4, 0);
    chk("rst_data", data4, 0);
    chk("rst_denied", den4, 0);
    chk("rst_count", cnt4, 0);

    // L word, L reader
    do_write(2'd1, 16'hBEEF, 1'b0);
    do_read(2'd1, 1'b0, 0, 1'b0);

    // H word: refused to L, released to H
    do_write(2'd2, 16'h1234, 1'b1);
    do_read(2'd2, 1'b0, 0, 1'b0);
    chk("first_denial_count", cnt4, 1);
    do_read(2'd2, 1'b1, 0, 1'b0);

    // backpressure for 5 cycles, with a write landing during RESP
    do_read(2'd2, 1'b0, 5, 1'b1);
    do_read(2'd2, 1'b0, 0, 1'b0);

    // write in the LOOKUP cycle is not seen by that read
    do_write(2'd3, 16'h00AA, 1'b0);
    predict(3, 1'b0, ed, eden);
    rd_req_valid = 1'b1; rd_idx = 2'd3; rd_clr = 1'b0; rd_resp_ready = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    wr_en = 1'b1; wr_idx = 2'd3; wr_data = 16'h5555; wr_tag = 1'b1;
    chk("coll_lookup_valid", vld4, 0);
    tick();
    wr_en = 1'b0;
    model_write(3, 16'h5555, 1'b1);
    chk_resp(ed, eden);
    tick();
    do_read(2'd3, 1'b0, 0, 1'b0);

    // idx 3 is outside the DEPTH=3 build even for an H reader
    do_write(2'd3, 16'h7777, 1'b0);
    do_read(2'd3, 1'b1, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(2'($urandom), 16'($urandom), 1'($urandom));
      else
        do_read(2'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end

    // saturation
    do_write(2'd2, 16'h1234, 1'b1);
    for (int n = 0; n < 300; n++) do_read(2'd2, 1'b0, 0, 1'b0);
    chk("sat_count4", cnt4, 255);
    chk("sat_count3", cnt3, 255);

    // reset while a request sits in LOOKUP
    rd_req_valid = 1'b1; rd_idx = 2'd1; rd_clr = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("midrst_req_ready", rdy4, 1);
    chk("midrst_resp_valid", vld4, 0);
    chk("midrst_data", data4, 0);
    chk("midrst_denied", den4, 0);
    chk("midrst_count", cnt4, 0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("midrst_no_resp", vld4, 0);
    end
    do_read(2'd2, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
